// File: rtl/rotary_multi_controller_pkg.sv
// Shared types for the rotary encoder front end.
//   rot_state_e : per-channel quadrature decoder state (3-bit code)
//   step_dir_e  : detent direction produced by the decoder on return to IDLE
package rotary_multi_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A1   = 3'd1,
    ST_A2   = 3'd2,
    ST_A3   = 3'd3,
    ST_B1   = 3'd4,
    ST_B2   = 3'd5,
    ST_B3   = 3'd6
  } rot_state_e;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2
  } step_dir_e;

endpackage

// File: rtl/rotary_multi_controller_channel.sv
// One encoder channel: 2-flop sync, per-pin debounce, detent decoder and bounded level.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   rotary_a, rotary_b  raw asynchronous encoder pins
//   load, load_value    preload strobe and value (clamped into MIN..MAX)
//   level               current level (registered)
//   step_up, step_dn    1-cycle pulses per accepted detent (registered)
module rotary_multi_controller_channel
  import rotary_multi_controller_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned RESET_LEVEL     = 14,
  parameter int unsigned MIN_LEVEL       = 0,
  parameter int unsigned MAX_LEVEL       = 15,
  parameter int unsigned WRAP            = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rotary_a,
  input  logic             rotary_b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] level,
  output logic             step_up,
  output logic             step_dn
);

  localparam int unsigned LW       = WIDTH + 1;
  localparam int unsigned CNT_W    = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CNT_LAST = (DEBOUNCE_CYCLES == 0) ? 0 : DEBOUNCE_CYCLES - 1;

  // Pin pairs are packed as {a, b}
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            filt_q, filt_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  rot_state_e            state_q, state_d;
  logic [WIDTH-1:0]      level_q, level_d;
  logic                  step_up_q, step_up_d;
  logic                  step_dn_q, step_dn_d;

  logic [1:0]            ab;
  step_dir_e             step_dir;
  logic [LW-1:0]         level_ext;
  logic [LW-1:0]         load_ext;

  // Synchroniser and debounce: a pin is accepted after DEBOUNCE_CYCLES consecutive differing cycles
  always_comb begin
    sync1_d = {rotary_a, rotary_b};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(CNT_LAST)) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign ab = (DEBOUNCE_CYCLES == 0) ? sync2_q : filt_q;

  // Detent decoder: A leading walks A1..A3 (decrement), B leading walks B1..B3 (increment)
  always_comb begin
    state_d  = state_q;
    step_dir = STEP_NONE;
    case (state_q)
      ST_IDLE: begin
        case (ab)
          2'b10:   state_d = ST_A1;
          2'b01:   state_d = ST_B1;
          default: state_d = ST_IDLE;
        endcase
      end
      ST_A1: begin
        case (ab)
          2'b00:   state_d = ST_IDLE;
          2'b10:   state_d = ST_A1;
          default: state_d = ST_A2;
        endcase
      end
      ST_A2: begin
        case (ab)
          2'b10:   state_d = ST_A1;
          2'b01:   state_d = ST_A3;
          2'b11:   state_d = ST_A2;
          default: begin
            state_d  = ST_IDLE;
            step_dir = STEP_DEC;
          end
        endcase
      end
      ST_A3: begin
        if (ab[1]) begin
          state_d = ST_A2;
        end else if (ab[0]) begin
          state_d = ST_A3;
        end else begin
          state_d  = ST_IDLE;
          step_dir = STEP_DEC;
        end
      end
      ST_B1: begin
        case (ab)
          2'b00:   state_d = ST_IDLE;
          2'b01:   state_d = ST_B1;
          default: state_d = ST_B2;
        endcase
      end
      ST_B2: begin
        case (ab)
          2'b01:   state_d = ST_B1;
          2'b10:   state_d = ST_B3;
          2'b11:   state_d = ST_B2;
          default: begin
            state_d  = ST_IDLE;
            step_dir = STEP_INC;
          end
        endcase
      end
      ST_B3: begin
        if (ab[0]) begin
          state_d = ST_B2;
        end else if (ab[1]) begin
          state_d = ST_B3;
        end else begin
          state_d  = ST_IDLE;
          step_dir = STEP_INC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Level update; load wins over a same-cycle detent and suppresses its pulse
  always_comb begin
    level_ext = {1'b0, level_q};
    load_ext  = {1'b0, load_value};
    level_d   = level_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    if (load) begin
      if (load_ext > LW'(MAX_LEVEL)) begin
        level_d = WIDTH'(MAX_LEVEL);
      end else if (load_ext <= LW'(MIN_LEVEL)) begin
        level_d = WIDTH'(MIN_LEVEL);
      end else begin
        level_d = load_value;
      end
    end else if (step_dir == STEP_INC) begin
      step_up_d = 1'b1;
      if (level_ext >= LW'(MAX_LEVEL)) begin
        level_d = (WRAP != 0) ? WIDTH'(MIN_LEVEL) : level_q;
      end else begin
        level_d = WIDTH'(level_ext + LW'(1));
      end
    end else if (step_dir == STEP_DEC) begin
      step_dn_d = 1'b1;
      if (level_ext <= LW'(MIN_LEVEL)) begin
        level_d = (WRAP != 0) ? WIDTH'(MAX_LEVEL) : level_q;
      end else begin
        level_d = WIDTH'(level_ext - LW'(1));
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= '0;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      level_q   <= WIDTH'(RESET_LEVEL);
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      filt_q    <= filt_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      level_q   <= level_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
    end
  end

  assign level   = level_q;
  assign step_up = step_up_q;
  assign step_dn = step_dn_q;

endmodule

// File: rtl/rotary_multi_controller.sv
// N-channel quadrature rotary encoder front end.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   rotary_a, rotary_b  raw encoder pins, one bit per channel
//   load                per-channel preload strobe
//   load_value          preload value shared by all channels
//   level               flattened levels, channel i at [i*WIDTH +: WIDTH]
//   step_up, step_dn    per-channel detent pulses
module rotary_multi_controller #(
  parameter int unsigned CHANNELS        = 1,
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned RESET_LEVEL     = 14,
  parameter int unsigned MIN_LEVEL       = 0,
  parameter int unsigned MAX_LEVEL       = 15,
  parameter int unsigned WRAP            = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       rotary_a,
  input  logic [CHANNELS-1:0]       rotary_b,
  input  logic [CHANNELS-1:0]       load,
  input  logic [WIDTH-1:0]          load_value,
  output logic [CHANNELS*WIDTH-1:0] level,
  output logic [CHANNELS-1:0]       step_up,
  output logic [CHANNELS-1:0]       step_dn
);

  // Independent channel instances
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    rotary_multi_controller_channel #(
      .WIDTH           (WIDTH),
      .RESET_LEVEL     (RESET_LEVEL),
      .MIN_LEVEL       (MIN_LEVEL),
      .MAX_LEVEL       (MAX_LEVEL),
      .WRAP            (WRAP),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .rotary_a   (rotary_a[i]),
      .rotary_b   (rotary_b[i]),
      .load       (load[i]),
      .load_value (load_value),
      .level      (level[i*WIDTH +: WIDTH]),
      .step_up    (step_up[i]),
      .step_dn    (step_dn[i])
    );
  end

endmodule

// File: tb/tb_rotary_multi_controller.sv
// Directed bench: default saturating instance, wrapping 0..9 instance and a 2-channel instance.
module tb_rotary_multi_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  always #5 clk = ~clk;

  // dut0 (saturating 0..15) and dutw (wrapping 0..9) share the encoder pins
  logic [0:0] pa, pb;
  logic [0:0] load0, loadw, up0, dn0, upw, dnw;
  logic [3:0] lv0, lvw, level0, levelw;
  logic [1:0] a2, b2, load2, up2, dn2;
  logic [3:0] lv2;
  logic [7:0] level2;

  rotary_multi_controller dut0 (
    .clk(clk), .reset_n(reset_n), .rotary_a(pa), .rotary_b(pb), .load(load0),
    .load_value(lv0), .level(level0), .step_up(up0), .step_dn(dn0)
  );

  rotary_multi_controller #(.RESET_LEVEL(0), .MIN_LEVEL(0), .MAX_LEVEL(9), .WRAP(1)) dutw (
    .clk(clk), .reset_n(reset_n), .rotary_a(pa), .rotary_b(pb), .load(loadw),
    .load_value(lvw), .level(levelw), .step_up(upw), .step_dn(dnw)
  );

  rotary_multi_controller #(.CHANNELS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .rotary_a(a2), .rotary_b(b2), .load(load2),
    .load_value(lv2), .level(level2), .step_up(up2), .step_dn(dn2)
  );

  int cyc = 0;
  int n_up0 = 0, n_dn0 = 0, n_upw = 0, n_dnw = 0, t_up0 = 0;
  int n_up2_0 = 0, n_dn2_0 = 0, n_up2_1 = 0, n_dn2_1 = 0, t_up2_0 = 0, t_dn2_1 = 0;
  int n_checks = 0, n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and last-pulse timestamps
  always @(negedge clk) begin
    if (up0[0]) begin n_up0 <= n_up0 + 1; t_up0 <= cyc; end
    if (dn0[0]) n_dn0 <= n_dn0 + 1;
    if (upw[0]) n_upw <= n_upw + 1;
    if (dnw[0]) n_dnw <= n_dnw + 1;
    if (up2[0]) begin n_up2_0 <= n_up2_0 + 1; t_up2_0 <= cyc; end
    if (dn2[0]) n_dn2_0 <= n_dn2_0 + 1;
    if (up2[1]) n_up2_1 <= n_up2_1 + 1;
    if (dn2[1]) begin n_dn2_1 <= n_dn2_1 + 1; t_dn2_1 <= cyc; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pins(input logic a, input logic b);
    pa = a; pb = b;
    tick(8);
  endtask

  int b_up0, b_dn0, b_upw, b_dnw, b_u20, b_d20, b_u21, b_d21, t0;

  task automatic snap();
    b_up0 = n_up0; b_dn0 = n_dn0; b_upw = n_upw; b_dnw = n_dnw;
    b_u20 = n_up2_0; b_d20 = n_dn2_0; b_u21 = n_up2_1; b_d21 = n_dn2_1;
  endtask

  initial begin
    reset_n = 1'b0;
    pa = '0; pb = '0; a2 = '0; b2 = '0;
    load0 = '0; loadw = '0; load2 = '0; lv0 = '0; lvw = '0; lv2 = '0;
    tick(3);
    reset_n = 1'b1;

    // Reset defaults, pins idle for 20 cycles
    snap();
    tick(20);
    check("rst_level0", 32'(level0), 32'd14);
    check("rst_levelw", 32'(levelw), 32'd0);
    check("rst_level2", 32'(level2), 32'hEE);
    check("rst_pulses", 32'((n_up0 - b_up0) + (n_dn0 - b_dn0) + (n_up2_0 - b_u20) + (n_dn2_1 - b_d21)), 32'd0);

    // B-leading detent: 14 -> 15, pulse 7 cycles after final 00
    snap();
    pins(1'b0, 1'b1); pins(1'b1, 1'b1); pins(1'b1, 1'b0);
    pa = 1'b0; pb = 1'b0; t0 = cyc;
    tick(12);
    check("inc_level", 32'(level0), 32'd15);
    check("inc_up_cnt", 32'(n_up0 - b_up0), 32'd1);
    check("inc_dn_cnt", 32'(n_dn0 - b_dn0), 32'd0);
    check("inc_latency", 32'(t_up0 - t0), 32'd7);
    check("inc_levelw", 32'(levelw), 32'd1);

    // Second detent saturates but still pulses
    snap();
    pins(1'b0, 1'b1); pins(1'b1, 1'b1); pins(1'b1, 1'b0); pins(1'b0, 1'b0); tick(4);
    check("sat_level", 32'(level0), 32'd15);
    check("sat_up_cnt", 32'(n_up0 - b_up0), 32'd1);

    // Wrap below MIN: dutw at 0, A-leading detent -> 9
    loadw = 1'b1; lvw = 4'd0; tick(1); loadw = 1'b0; tick(1);
    check("ldw_zero", 32'(levelw), 32'd0);
    snap();
    pins(1'b1, 1'b0); pins(1'b1, 1'b1); pins(1'b0, 1'b1); pins(1'b0, 1'b0); tick(4);
    check("wrap_dn_level", 32'(levelw), 32'd9);
    check("wrap_dn_cnt", 32'(n_dnw - b_dnw), 32'd1);
    check("dec_level0", 32'(level0), 32'd14);
    check("dec_dn0_cnt", 32'(n_dn0 - b_dn0), 32'd1);

    // Bounce on A shorter than the debounce window
    snap();
    repeat (4) begin
      pa = 1'b1; tick(3);
      pa = 1'b0; tick(3);
    end
    tick(10);
    check("bounce_level", 32'(level0), 32'd14);
    check("bounce_pulses", 32'((n_up0 - b_up0) + (n_dn0 - b_dn0) + (n_upw - b_upw) + (n_dnw - b_dnw)), 32'd0);
    pins(1'b0, 1'b1); pins(1'b1, 1'b1); pins(1'b1, 1'b0); pins(1'b0, 1'b0); tick(4);
    check("post_bounce_inc", 32'(level0), 32'd15);

    // Load clamping and plain load
    loadw = 1'b1; lvw = 4'd12; load0 = 1'b1; lv0 = 4'd5; tick(1);
    loadw = 1'b0; load0 = 1'b0; tick(1);
    check("ld_clamp_max", 32'(levelw), 32'd9);
    check("ld_plain", 32'(level0), 32'd5);

    // Load coincident with detent commit on dut0; dutw wraps 9 -> 0 on the same detent
    snap();
    pins(1'b0, 1'b1); pins(1'b1, 1'b1); pins(1'b1, 1'b0);
    pa = 1'b0; pb = 1'b0;
    tick(6);
    load0 = 1'b1; lv0 = 4'd3;
    tick(1);
    load0 = 1'b0;
    tick(8);
    check("ld_commit_level", 32'(level0), 32'd3);
    check("ld_commit_up", 32'(n_up0 - b_up0), 32'd0);
    check("wrap_up_level", 32'(levelw), 32'd0);
    check("wrap_up_cnt", 32'(n_upw - b_upw), 32'd1);

    // Two channels complete opposite detents together
    snap();
    a2 = 2'b10; b2 = 2'b01; tick(8);
    a2 = 2'b11; b2 = 2'b11; tick(8);
    a2 = 2'b01; b2 = 2'b10; tick(8);
    a2 = 2'b00; b2 = 2'b00; t0 = cyc;
    tick(12);
    check("mc_levels", 32'(level2), 32'hDF);
    check("mc_up0_cnt", 32'(n_up2_0 - b_u20), 32'd1);
    check("mc_dn1_cnt", 32'(n_dn2_1 - b_d21), 32'd1);
    check("mc_up0_time", 32'(t_up2_0 - t0), 32'd7);
    check("mc_dn1_time", 32'(t_dn2_1 - t0), 32'd7);

    // Reset mid-detent on ch0 discards the partial detent
    a2 = 2'b00; b2 = 2'b01; tick(8);
    a2 = 2'b01; b2 = 2'b11; tick(8);
    reset_n = 1'b0; tick(2); reset_n = 1'b1;
    snap();
    tick(1);
    check("mid_rst_level2", 32'(level2), 32'hEE);
    check("mid_rst_level0", 32'(level0), 32'd14);
    a2 = 2'b01; b2 = 2'b00; tick(8);
    a2 = 2'b00; b2 = 2'b00; tick(12);
    check("mid_rst_hold", 32'(level2), 32'hEE);
    check("mid_rst_pulses", 32'((n_up2_0 - b_u20) + (n_dn2_0 - b_d20) + (n_up2_1 - b_u21) + (n_dn2_1 - b_d21)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
